regfile_writeback: RTL and testbench

//  Write-side front end of the register file: merges results from the ALU and memory

---
 rtl/regfile_writeback_if.sv | 31 +++
 rtl/regfile_writeback.sv | 63 ++++++
 tb/tb_regfile_writeback.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer channels, issue allocation, scoreboard and regfile write port
interface regfile_writeback_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int NREGS  = 2 ** IDX_W
);
    logic              alu_valid;
    logic              alu_ready;
    logic [IDX_W-1:0]  alu_idx;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_data;
    logic              alloc_en;
    logic [IDX_W-1:0]  alloc_idx;
    logic [NREGS-1:0]  busy;
    logic              we;
    logic [IDX_W-1:0]  windex;
    logic [DATA_W-1:0] win;

    modport master (
        output alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data, alloc_en, alloc_idx,
        input  alu_ready, mem_ready, busy, we, windex, win
    );

    modport slave (
        input  alu_valid, alu_idx, alu_data, mem_valid, mem_idx, mem_data, alloc_en, alloc_idx,
        output alu_ready, mem_ready, busy, we, windex, win
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: round-robin merge of ALU and load results into the regfile write port,
// plus a pending-write scoreboard set at issue and cleared at writeback acceptance.
module regfile_writeback #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int NREGS  = 2 ** IDX_W
) (
    input logic clk,
    input logic rst_n,
    regfile_writeback_if.slave bus
);
    localparam logic [NREGS-1:0] one_bit = 1;

    logic              last_mem;
    logic              alu_fire;
    logic              mem_fire;
    logic              fire;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [NREGS-1:0]  clr;
    logic [NREGS-1:0]  set;
    logic [NREGS-1:0]  busy_q;
    logic              we_q;
    logic [IDX_W-1:0]  windex_q;
    logic [DATA_W-1:0] win_q;

    // On a tie the channel not granted last wins; reset leaves MEM as last so ALU goes first.
    always_comb begin
        bus.alu_ready = bus.alu_valid && (!bus.mem_valid || last_mem);
        bus.mem_ready = bus.mem_valid && (!bus.alu_valid || !last_mem);
        alu_fire = bus.alu_valid && bus.alu_ready;
        mem_fire = bus.mem_valid && bus.mem_ready;
        fire = alu_fire || mem_fire;
        idx = alu_fire ? bus.alu_idx : bus.mem_idx;
        data = alu_fire ? bus.alu_data : bus.mem_data;
        clr = (fire && idx != '0) ? one_bit << idx : '0;
        set = (bus.alloc_en && bus.alloc_idx != '0) ? one_bit << bus.alloc_idx : '0;
    end

    // OR-ing set after masking clr makes a same-edge alloc win over the writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_mem <= 1'b1;
            busy_q <= '0;
            we_q <= 1'b0;
            windex_q <= '0;
            win_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr) | set;
            we_q <= fire && idx != '0;
            if (fire) begin
                last_mem <= mem_fire;
                windex_q <= idx;
                win_q <= data;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.we = we_q;
    assign bus.windex = windex_q;
    assign bus.win = win_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios for the writeback merge and scoreboard.
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    regfile_writeback_if #(.DATA_W(32), .IDX_W(5)) bus ();

    regfile_writeback #(.DATA_W(32), .IDX_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_idx = '0;
        bus.alu_data = '0;
        bus.mem_valid = 1'b0;
        bus.mem_idx = '0;
        bus.mem_data = '0;
        bus.alloc_en = 1'b0;
        bus.alloc_idx = '0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        #1;
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.we); end
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
        n_checks++; if (bus.windex !== 5'd0 || bus.win !== 32'h0) begin n_fail++; $display("FAIL reset_wport: got %0d/%h want 0/0", bus.windex, bus.win); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_stream();
        idle();
        bus.alloc_en = 1'b1; bus.alloc_idx = 5'd5;
        tick();
        bus.alloc_idx = 5'd7;
        tick();
        bus.alloc_en = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_idx = 5'd1; bus.alu_data = 32'h99;
        tick();
        idle();
        n_checks++; if (bus.we !== 1'b1 || bus.busy !== 32'h0000_00A0) begin n_fail++; $display("FAIL mid_pre: got we=%b busy=%h want 1/000000a0", bus.we, bus.busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.we !== 1'b0 || bus.busy !== 32'h0) begin n_fail++; $display("FAIL mid_async: got we=%b busy=%h want 0/0", bus.we, bus.busy); end
        rst_n = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_idx = 5'd3; bus.alu_data = 32'h33;
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd4; bus.mem_data = 32'h44;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_tie: got alu=%b mem=%b want 1/0", bus.alu_ready, bus.mem_ready); end
        tick();
        idle();
        n_checks++; if (bus.we !== 1'b1 || bus.windex !== 5'd3) begin n_fail++; $display("FAIL mid_tie_write: got we=%b idx=%0d want 1/3", bus.we, bus.windex); end
        tick();
    endtask

    task automatic test_single_write();
        idle();
        bus.alloc_en = 1'b1; bus.alloc_idx = 5'd5;
        tick();
        n_checks++; if (bus.busy[5] !== 1'b1) begin n_fail++; $display("FAIL single_alloc: got %b want 1", bus.busy[5]); end
        bus.alloc_en = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_idx = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", bus.alu_ready); end
        tick();
        idle();
        n_checks++; if (bus.busy[5] !== 1'b0) begin n_fail++; $display("FAIL single_clear: got %b want 0", bus.busy[5]); end
        n_checks++; if (bus.we !== 1'b1 || bus.windex !== 5'd5 || bus.win !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write: got %b/%0d/%h want 1/5/deadbeef", bus.we, bus.windex, bus.win); end
        tick();
        n_checks++; if (bus.we !== 1'b0 || bus.windex !== 5'd5) begin n_fail++; $display("FAIL single_after: got we=%b idx=%0d want 0/5", bus.we, bus.windex); end
    endtask

    task automatic test_contention();
        idle();
        pulse_reset();
        bus.alu_valid = 1'b1; bus.alu_idx = 5'd1; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd2; bus.mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus.alu_ready !== (i % 2 == 0) || bus.mem_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL cont_ready%0d: got alu=%b mem=%b want alu=%b", i, bus.alu_ready, bus.mem_ready, i % 2 == 0); end
            tick();
            n_checks++; if (bus.we !== 1'b1 || bus.windex !== ((i % 2 == 0) ? 5'd1 : 5'd2) || bus.win !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin n_fail++; $display("FAIL cont_write%0d: got %b/%0d/%h", i, bus.we, bus.windex, bus.win); end
        end
        idle();
        tick();
    endtask

    task automatic test_zero_reg();
        idle();
        bus.alu_valid = 1'b1; bus.alu_idx = 5'd0; bus.alu_data = 32'h55;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", bus.alu_ready); end
        tick();
        idle();
        n_checks++; if (bus.we !== 1'b0 || bus.windex !== 5'd0 || bus.win !== 32'h55) begin n_fail++; $display("FAIL zero_write: got %b/%0d/%h want 0/0/55", bus.we, bus.windex, bus.win); end
        bus.alloc_en = 1'b1; bus.alloc_idx = 5'd0;
        tick();
        idle();
        n_checks++; if (bus.busy !== 32'h0) begin n_fail++; $display("FAIL zero_alloc: got %h want 0", bus.busy); end
    endtask

    task automatic test_collision();
        idle();
        bus.alloc_en = 1'b1; bus.alloc_idx = 5'd7;
        tick();
        n_checks++; if (bus.busy[7] !== 1'b1) begin n_fail++; $display("FAIL coll_pre: got %b want 1", bus.busy[7]); end
        bus.mem_valid = 1'b1; bus.mem_idx = 5'd7; bus.mem_data = 32'h77;
        #1;
        n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready: got %b want 1", bus.mem_ready); end
        tick();
        idle();
        n_checks++; if (bus.busy !== 32'h0000_0080) begin n_fail++; $display("FAIL coll_busy: got %h want 00000080", bus.busy); end
        n_checks++; if (bus.we !== 1'b1 || bus.windex !== 5'd7 || bus.win !== 32'h77) begin n_fail++; $display("FAIL coll_write: got %b/%0d/%h want 1/7/77", bus.we, bus.windex, bus.win); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.mem_valid = 1'b1; bus.mem_idx = 5'(3 + i); bus.mem_data = 32'h30 + 32'(i);
            #1;
            n_checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL stream_ready%0d: got mem=%b alu=%b want 1/0", i, bus.mem_ready, bus.alu_ready); end
            tick();
            n_checks++; if (bus.we !== 1'b1 || bus.windex !== 5'(3 + i) || bus.win !== 32'h30 + 32'(i)) begin n_fail++; $display("FAIL stream_write%0d: got %b/%0d/%h", i, bus.we, bus.windex, bus.win); end
        end
        idle();
        tick();
        n_checks++; if (bus.we !== 1'b0 || bus.windex !== 5'd6) begin n_fail++; $display("FAIL stream_end: got we=%b idx=%0d want 0/6", bus.we, bus.windex); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_reset_mid_stream();
        test_contention();
        test_zero_reg();
        test_collision();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
